surv_wr_arbiter: RTL and testbench

Round-robin write arbiter sharing the survivor shift-memory write port among the eight ACS lanes of the pipelined Viterbi decoder. Each lane presents a 15-bit packed word {data_id, addr_4, dec_bit_4, addr_3, dec_bit_3, addr_2, dec_bit_2, addr_1, dec_bit_1} with a valid/ready handshake; the arbiter serialises them into a registered single-port stream toward shift_mem. It tracks trellis-stage completion per data_id and signals when all lanes have written a stage.

---
 rtl/surv_arb_pkg.sv | 30 +++
 rtl/surv_wr_arbiter_rr_pick8.sv | 30 +++
 rtl/surv_wr_arbiter.sv | 115 +++++++++++
 tb/tb_surv_wr_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/surv_arb_pkg.sv
// Shared types and constants for the survivor-memory write arbiter.
// Optional feature macro used by the arbiter: SURV_ARB_ID_CHECK_EN.
package surv_arb_pkg;

    localparam int N_REQ = 8;
    localparam int W     = 15;
    localparam int ID_W  = 3;

    typedef logic [2:0]      lane_idx_t;
    typedef logic [ID_W-1:0] data_id_t;

    // Lane word layout, MSB first; addresses are 2 bits, decision bits 1 bit.
    typedef struct packed {
        data_id_t   data_id;
        logic [1:0] addr_4;
        logic       dec_bit_4;
        logic [1:0] addr_3;
        logic       dec_bit_3;
        logic [1:0] addr_2;
        logic       dec_bit_2;
        logic [1:0] addr_1;
        logic       dec_bit_1;
    } lane_word_t;

    // Pulls the data_id field out of a raw lane word.
    function automatic data_id_t data_id_of(input logic [W-1:0] word);
        return word[W-1:W-ID_W];
    endfunction

endpackage

// File: rtl/surv_wr_arbiter_rr_pick8.sv
// Combinational 8-way rotating-priority picker: the search starts at ptr
// and wraps, returning the first set bit of eligible as one-hot and index.
module rr_pick8
    import surv_arb_pkg::*;
(
    input  logic [7:0] eligible,
    input  lane_idx_t  ptr,
    output logic [7:0] grant,
    output lane_idx_t  index,
    output logic       any
);

    // First eligible lane at or after ptr, modulo 8.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        grant = 8'h00;
        index = '0;
        any   = 1'b0;
        for (int k = 0; k < 8; k++) begin
            lane_idx_t cand;
            cand = ptr + lane_idx_t'(k);
            if (!any && eligible[cand]) begin
                any         = 1'b1;
                index       = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/surv_wr_arbiter.sv
// Round-robin write arbiter: serialises eight ACS-lane words into one
// registered stream toward shift_mem and tracks per-stage completion.
// Optional: define SURV_ARB_ID_CHECK_EN to gate lanes on data_id == cur_id
// and flag illegal data_ids on id_err; otherwise data_id is ignored.
module surv_wr_arbiter
    import surv_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*W-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    output logic               mem_valid,
    input  logic               mem_ready,
    output logic [W-1:0]       mem_data,
    output lane_idx_t          mem_src,
    output data_id_t           cur_id,
    output logic               stage_done,
    output logic               id_err
);

    lane_word_t       words [N_REQ];
    logic [N_REQ-1:0] served;
    lane_idx_t        rr_ptr;
    logic [N_REQ-1:0] id_ok;
    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] pick_oh;
    lane_idx_t        pick_idx;
    logic             pick_any;
    logic             slot_free;
    logic             stage_full;

    // Unpack the flat lane bus into typed words.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            words[i] = lane_word_t'(req_data[i*W +: W]);
        end
    end

`ifdef SURV_ARB_ID_CHECK_EN
    logic [N_REQ-1:0] id_bad;
    data_id_t         next_id;

    assign next_id = cur_id + data_id_t'(1);

    // A lane is usable only for the current stage; the next stage waits
    // quietly, anything else is an error.
    always_comb begin
        id_ok  = '0;
        id_bad = '0;
        for (int i = 0; i < N_REQ; i++) begin
            id_ok[i]  = (words[i].data_id == cur_id);
            id_bad[i] = req_valid[i] && (words[i].data_id != cur_id)
                                     && (words[i].data_id != next_id);
        end
    end

    // Error pulse follows the cycle in which the bad id was seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_err <= 1'b0;
        end else begin
            id_err <= |id_bad;
        end
    end
`else
    assign id_ok  = '1;
    assign id_err = 1'b0;
`endif

    assign slot_free  = !mem_valid || mem_ready;
    assign stage_full = (served == 8'hFF);
    assign stage_done = stage_full;
    assign eligible   = slot_free ? (req_valid & ~served & id_ok) : '0;

    rr_pick8 u_pick (
        .eligible (eligible),
        .ptr      (rr_ptr),
        .grant    (pick_oh),
        .index    (pick_idx),
        .any      (pick_any)
    );

    assign req_ready = pick_oh;

    // Output register, round-robin pointer and stage bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values.
            mem_valid <= 1'b0;
            mem_data  <= '0;
            mem_src   <= '0;
            rr_ptr    <= '0;
            served    <= '0;
            cur_id    <= '0;
        end else begin
            if (pick_any) begin
                mem_valid <= 1'b1;
                mem_data  <= words[pick_idx];
                mem_src   <= pick_idx;
                rr_ptr    <= pick_idx + lane_idx_t'(1);
            end else if (mem_ready) begin
                mem_valid <= 1'b0;
            end

            if (stage_full) begin
                served <= '0;
                cur_id <= cur_id + data_id_t'(1);
            end else if (pick_any) begin
                served <= served | pick_oh;
            end
        end
    end

endmodule

// File: tb/tb_surv_wr_arbiter.sv
// Directed self-checking bench for surv_wr_arbiter. With
// SURV_ARB_ID_CHECK_EN defined it additionally exercises the data_id checks.
module tb_surv_wr_arbiter;

    logic          clk;
    logic          rst;
    logic [7:0]    req_valid;
    logic [119:0]  req_data;
    logic [7:0]    req_ready;
    logic          mem_valid;
    logic          mem_ready;
    logic [14:0]   mem_data;
    logic [2:0]    mem_src;
    logic [2:0]    cur_id;
    logic          stage_done;
    logic          id_err;

    int n_checks = 0;
    int n_err    = 0;

    surv_wr_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_data   (mem_data),
        .mem_src    (mem_src),
        .cur_id     (cur_id),
        .stage_done (stage_done),
        .id_err     (id_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [14:0] mk_word(input logic [2:0] id, input logic [2:0] lane);
        return {id, 12'h5A3 ^ {lane, lane, lane, lane}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int lane, input logic [2:0] id);
        req_data[lane*15 +: 15] = mk_word(id, 3'(lane));
    endtask

    task automatic set_all_words(input logic [2:0] id);
        for (int i = 0; i < 8; i++) set_word(i, id);
    endtask

    // Present a valid mask, expect lane exp_lane to win and appear next cycle.
    task automatic grant_step(input logic [7:0] mask, input int exp_lane, input logic [2:0] id);
        req_valid = mask;
        #1;
        check("req_ready_grant", 32'(req_ready), 32'(8'h01 << exp_lane));
        tick();
        check("mem_valid_after_grant", 32'(mem_valid), 32'd1);
        check("mem_src_after_grant", 32'(mem_src), 32'(exp_lane));
        check("mem_data_after_grant", 32'(mem_data), 32'(mk_word(id, 3'(exp_lane))));
    endtask

    // Idle cycle expected to be the stage_done cycle; checks the id advance.
    task automatic expect_stage_done(input logic [2:0] id);
        req_valid = 8'h00;
        #1;
        check("stage_done_pulse", 32'(stage_done), 32'd1);
        check("no_grant_in_done", 32'(req_ready), 32'd0);
        tick();
        check("stage_done_cleared", 32'(stage_done), 32'd0);
        check("cur_id_advance", 32'(cur_id), 32'(3'(id + 3'd1)));
        check("mem_valid_drained", 32'(mem_valid), 32'd0);
    endtask

    // Full stage with all lanes valid starting from rr_ptr = 0.
    task automatic run_full_stage(input logic [2:0] id);
        set_all_words(id);
        for (int k = 0; k < 8; k++) begin
            grant_step(8'(8'hFF << k), k, id);
            check("no_early_done", 32'(stage_done), 32'(k == 7));
        end
        expect_stage_done(id);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 8'h00;
        req_data  = '0;
        mem_ready = 1'b1;

        // Reset state.
        tick();
        tick();
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_mem_data", 32'(mem_data), 32'd0);
        check("rst_mem_src", 32'(mem_src), 32'd0);
        check("rst_cur_id", 32'(cur_id), 32'd0);
        check("rst_stage_done", 32'(stage_done), 32'd0);
        check("rst_id_err", 32'(id_err), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        tick();

        // Stage 0: all lanes, sources 0..7 back to back.
        run_full_stage(3'd0);

        // Stage 1: lane 3 withheld so the stage ends on lane 3 (rr_ptr -> 4).
        set_all_words(3'd1);
        grant_step(8'hF7, 0, 3'd1);
        grant_step(8'hF6, 1, 3'd1);
        grant_step(8'hF4, 2, 3'd1);
        grant_step(8'hF0, 4, 3'd1);
        grant_step(8'hE0, 5, 3'd1);
        grant_step(8'hC0, 6, 3'd1);
        grant_step(8'h80, 7, 3'd1);
        // Lane 0 re-presents while already served: only lane 3 may win.
        grant_step(8'h09, 3, 3'd1);
        expect_stage_done(3'd1);

`ifdef SURV_ARB_ID_CHECK_EN
        // cur_id = 2: next-stage id waits silently, a stray id flags id_err.
        set_word(1, 3'd3);
        req_valid = 8'h02;
        #1;
        check("next_id_held", 32'(req_ready), 32'd0);
        tick();
        check("next_id_no_err", 32'(id_err), 32'd0);
        check("next_id_no_out", 32'(mem_valid), 32'd0);
        set_word(1, 3'd6);
        #1;
        check("bad_id_no_grant", 32'(req_ready), 32'd0);
        tick();
        check("bad_id_err", 32'(id_err), 32'd1);
        req_valid = 8'h00;
        tick();
        check("bad_id_err_clear", 32'(id_err), 32'd0);
`endif

        // Stage 2: lanes 3 and 5 with rr_ptr = 4 -> 5 first, then 3.
        set_all_words(3'd2);
        grant_step(8'h28, 5, 3'd2);
        grant_step(8'h08, 3, 3'd2);
        check("partial_no_done", 32'(stage_done), 32'd0);

        // Stall four cycles with the output occupied.
        mem_ready = 1'b0;
        req_valid = 8'h07;
        for (int s = 0; s < 4; s++) begin
            #1;
            check("stall_req_ready", 32'(req_ready), 32'd0);
            tick();
            check("stall_mem_valid", 32'(mem_valid), 32'd1);
            check("stall_mem_src", 32'(mem_src), 32'd3);
            check("stall_mem_data", 32'(mem_data), 32'(mk_word(3'd2, 3'd3)));
        end
        mem_ready = 1'b1;
        grant_step(8'h07, 0, 3'd2);
        grant_step(8'h06, 1, 3'd2);
        grant_step(8'h04, 2, 3'd2);
        check("five_granted_no_done", 32'(stage_done), 32'd0);

        // Asynchronous reset after five grants of the stage.
        req_valid = 8'h00;
        #2;
        rst = 1'b1;
        #1;
        check("arst_mem_valid", 32'(mem_valid), 32'd0);
        check("arst_mem_data", 32'(mem_data), 32'd0);
        check("arst_mem_src", 32'(mem_src), 32'd0);
        check("arst_cur_id", 32'(cur_id), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Fresh stage needs all eight lanes again, then cycle cur_id round to 0.
        for (int id = 0; id < 8; id++) begin
            run_full_stage(3'(id));
        end
        check("cur_id_wrapped", 32'(cur_id), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
